// File: rtl/pattern_loader_pkg.sv
// Shared types and sizing for the pattern buffer serial loader.
// Optional readback of old buffer contents is enabled by PATTERN_LOADER_READBACK_EN.
package pattern_loader_pkg;

  localparam int BUFFER_SIZE  = 22;
  localparam int BUFFER_WIDTH = 8;
  localparam int BIT_GAP      = 1;

  localparam int BYTE_CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int BIT_CNT_W  = $clog2(BUFFER_WIDTH);
  localparam int GAP_CNT_W  = $clog2(BIT_GAP + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT_HI,
    SHIFT_LO,
    DONE
  } state_e;

endpackage

// File: rtl/pattern_loader_ssel_pulse_gen.sv
// Shift strobe generator: one ssel-high cycle per fire, then BIT_GAP low cycles,
// with bit_done flagging the last low cycle of the gap.
module ssel_pulse_gen
  import pattern_loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  input  logic clear,
  output logic ssel,
  output logic bit_done
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(BIT_GAP - 1);

  logic                 ssel_q, ssel_d;
  logic                 gap_active_q, gap_active_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  assign bit_done = gap_active_q && (gap_cnt_q == GAP_LAST);

  // NOTE: every variable gets a default at the top of the block so no path infers a latch.
  always_comb begin
    ssel_d       = fire & ~clear & ~ssel_q;
    gap_active_d = gap_active_q;
    gap_cnt_d    = gap_cnt_q;
    if (clear) begin
      gap_active_d = 1'b0;
      gap_cnt_d    = '0;
    end else if (ssel_q) begin
      gap_active_d = 1'b1;
      gap_cnt_d    = '0;
    end else if (bit_done) begin
      gap_active_d = 1'b0;
      gap_cnt_d    = '0;
    end else if (gap_active_q) begin
      gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_q       <= 1'b0;
      gap_active_q <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      ssel_q       <= ssel_d;
      gap_active_q <= gap_active_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign ssel = ssel_q;

endmodule

// File: rtl/pattern_loader.sv
// Serial front-end for the pattern buffer: streams BUFFER_SIZE bytes MSB-first over ssel/sin.
// Define PATTERN_LOADER_READBACK_EN to capture the old buffer contents from sout.
module pattern_loader
  import pattern_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BUFFER_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ssel,
  output logic                    sin,
  input  logic                    sout,
  output logic                    busy,
  output logic                    done,
  output logic [BUFFER_WIDTH-1:0] rb_data,
  output logic                    rb_valid
);

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(BUFFER_WIDTH - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(BUFFER_SIZE - 1);

  state_e                  state_q, state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BUFFER_WIDTH-1:0] shift_q, shift_d;
  logic                    sin_q, sin_d;
  logic                    in_ready_q, in_ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fire, bit_done, abort_now;

  assign abort_now = abort && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sin_d      = sin_q;
    fire       = 1'b0;
    if (abort_now) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = WAIT_BYTE;
        WAIT_BYTE: begin
          if (in_valid && in_ready_q) begin
            shift_d = in_data;
            sin_d   = in_data[BUFFER_WIDTH-1];
            fire    = 1'b1;
            state_d = SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          shift_d = shift_q << 1;
          state_d = SHIFT_LO;
        end
        SHIFT_LO: begin
          if (bit_done) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (byte_cnt_q == BYTE_LAST) begin
                byte_cnt_d = '0;
                state_d    = DONE;
              end else begin
                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                state_d    = WAIT_BYTE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              sin_d     = shift_q[BUFFER_WIDTH-1];
              fire      = 1'b1;
              state_d   = SHIFT_HI;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they appear registered with the state.
    in_ready_d = (state_d == WAIT_BYTE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sin_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sin_q      <= sin_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  ssel_pulse_gen u_ssel_pulse_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .fire     (fire),
    .clear    (abort_now),
    .ssel     (ssel),
    .bit_done (bit_done)
  );

  assign in_ready = in_ready_q;
  assign sin      = sin_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef PATTERN_LOADER_READBACK_EN
  logic [BUFFER_WIDTH-1:0] rb_shift_q, rb_shift_d;
  logic [BUFFER_WIDTH-1:0] rb_data_q, rb_data_d;
  logic                    rb_valid_q, rb_valid_d;

  // sout is sampled at the edge that ends SHIFT_HI, i.e. before the buffer shifts.
  always_comb begin
    rb_shift_d = rb_shift_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (state_q == SHIFT_HI && !abort_now) begin
      rb_shift_d = {rb_shift_q[BUFFER_WIDTH-2:0], sout};
      if (bit_cnt_q == BIT_LAST) begin
        rb_data_d  = rb_shift_d;
        rb_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_shift_q <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_sout;
  assign unused_sout = sout;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule
